atm_port_readback: RTL and testbench

Read-side responder for the ATM pager port family. It serves Z80 `IN` cycles to port xxBE and returns the state held by the four 16 KB window pagers: pages, RAM/ROM flags, 7FFD-mode flags and write-disable flags. It sits beside the port decoder. It snapshots the selected pager state when a read is detected and holds the byte stable on `rd_data` until the I/O cycle ends. The write side (xFF7/x7F7/xBF7) stays in the pagers.

---
 rtl/atm_port_readback.sv | 108 ++++++++++
 tb/tb_atm_port_readback.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/atm_port_readback.sv
// ============================================================================
// Module   : atm_port_readback
// Brief    : Z80 IN responder for port xxBE; snapshots ATM window-pager state
//            (pages, RAM/ROM, 7FFD-mode, write-disable) and holds it for the
//            duration of the I/O read cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module atm_port_readback #(
    parameter logic [7:0] PORT_LO = 8'hBE
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        zpos,
    input  logic        zneg,
    input  logic [15:0] za,
    input  logic        iorq_n,
    input  logic        rd_n,
    input  logic        m1_n,
    input  logic        shadow_en,
    input  logic [31:0] page0,
    input  logic [31:0] page1,
    input  logic [7:0]  ramnrom,
    input  logic [7:0]  dos7ffd,
    input  logic [7:0]  wrdis,
    output logic [7:0]  rd_data,
    output logic        rd_valid
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_idx;
    logic [7:0]  r_rd_data;
    logic        r_rd_valid;
    logic        w_hit;
    logic        w_cycle_end;
    logic [31:0] w_page_sel;
    logic [7:0]  w_mux;
    logic        w_unused_zpos;

    // Only the falling Z80 edge qualifies a read; the rising strobe is not needed.
    assign w_unused_zpos = zpos;

    assign w_hit = zneg && !iorq_n && !rd_n && m1_n && shadow_en
                   && (za[7:0] == PORT_LO);
    assign w_cycle_end = iorq_n || rd_n;

    // Pagers keep pages inverted; undo that so reads match what was written.
    assign w_page_sel = r_idx[0] ? page1 : page0;

    always_comb begin
        w_mux = 8'hFF;
        if (r_idx[7:3] == 5'd0) begin
            w_mux = ~w_page_sel[{r_idx[2:1], 3'b000} +: 8];
        end else begin
            case (r_idx)
                8'h08:   w_mux = ramnrom;
                8'h09:   w_mux = dos7ffd;
                8'h0A:   w_mux = wrdis;
                default: w_mux = 8'hFF;
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_hit) w_state_next = S_CAPTURE;
            S_CAPTURE: w_state_next = w_cycle_end ? S_IDLE : S_HOLD;
            S_HOLD:    if (w_cycle_end) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= 8'h00;
            r_rd_data  <= 8'hFF;
            r_rd_valid <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && w_hit) begin
                r_idx <= za[15:8];
            end
            if (r_state == S_CAPTURE && !w_cycle_end) begin
                r_rd_data  <= w_mux;
                r_rd_valid <= 1'b1;
            end
            if (r_state == S_HOLD && w_cycle_end) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;

endmodule

`default_nettype wire

// File: tb/tb_atm_port_readback.sv
// ============================================================================
// Module   : tb_atm_port_readback
// Brief    : Randomized self-checking bench for atm_port_readback against a
//            transaction-level model of the pager readback map.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_atm_port_readback;

    logic        fclk;
    logic        rst;
    logic        zpos;
    logic        zneg;
    logic [15:0] za;
    logic        iorq_n;
    logic        rd_n;
    logic        m1_n;
    logic        shadow_en;
    logic [31:0] page0;
    logic [31:0] page1;
    logic [7:0]  ramnrom;
    logic [7:0]  dos7ffd;
    logic [7:0]  wrdis;
    logic [7:0]  rd_data;
    logic        rd_valid;

    // Model state: page values as written through x7F7 (pagers store them inverted).
    logic [7:0]  wr_pg0 [4];
    logic [7:0]  wr_pg1 [4];
    logic [7:0]  m_ramnrom;
    logic [7:0]  m_dos7ffd;
    logic [7:0]  m_wrdis;
    logic [7:0]  m_last;

    int n_checks = 0;
    int n_errors = 0;

    atm_port_readback #(.PORT_LO(8'hBE)) dut (
        .fclk      (fclk),
        .rst       (rst),
        .zpos      (zpos),
        .zneg      (zneg),
        .za        (za),
        .iorq_n    (iorq_n),
        .rd_n      (rd_n),
        .m1_n      (m1_n),
        .shadow_en (shadow_en),
        .page0     (page0),
        .page1     (page1),
        .ramnrom   (ramnrom),
        .dos7ffd   (dos7ffd),
        .wrdis     (wrdis),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    assign page0   = ~{wr_pg0[3], wr_pg0[2], wr_pg0[1], wr_pg0[0]};
    assign page1   = ~{wr_pg1[3], wr_pg1[2], wr_pg1[1], wr_pg1[0]};
    assign ramnrom = m_ramnrom;
    assign dos7ffd = m_dos7ffd;
    assign wrdis   = m_wrdis;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_byte(input logic [7:0] idx);
        int w;
        w = idx / 2;
        if (idx < 8)        return (idx % 2 == 1) ? wr_pg1[w] : wr_pg0[w];
        else if (idx == 8)  return m_ramnrom;
        else if (idx == 9)  return m_dos7ffd;
        else if (idx == 10) return m_wrdis;
        else                return 8'hFF;
    endfunction

    task automatic randomize_pagers();
        for (int i = 0; i < 4; i++) begin
            wr_pg0[i] = 8'($urandom);
            wr_pg1[i] = 8'($urandom);
        end
        m_ramnrom = 8'($urandom);
        m_dos7ffd = 8'($urandom);
        m_wrdis   = 8'($urandom);
    endtask

    // One complete Z80 IN cycle. Inputs change on negedge, outputs sampled on negedge.
    task automatic do_in(input logic [15:0] addr, input logic shadow, input logic m1,
                         input logic abort, input int hold, input logic mutate);
        logic       hit;
        logic [7:0] exp;
        hit = shadow && m1 && (addr[7:0] == 8'hBE) && !abort;
        @(negedge fclk);
        za = addr; iorq_n = 1'b0; rd_n = 1'b0; m1_n = m1; shadow_en = shadow; zneg = 1'b1;
        @(negedge fclk);
        zneg = 1'b0;
        chk("valid_T0", {31'd0, rd_valid}, 32'd0);
        if (abort) iorq_n = 1'b1;
        @(negedge fclk);
        if (hit) m_last = ref_byte(addr[15:8]);
        chk("valid_T1", {31'd0, rd_valid}, {31'd0, hit});
        chk("data_T1", {24'd0, rd_data}, {24'd0, m_last});
        exp = m_last;
        for (int i = 0; i < hold; i++) begin
            if (mutate) randomize_pagers();
            if (i == 0) shadow_en = 1'b0;
            @(negedge fclk);
            chk("valid_hold", {31'd0, rd_valid}, {31'd0, hit});
            chk("data_hold", {24'd0, rd_data}, {24'd0, exp});
        end
        iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1;
        @(negedge fclk);
        chk("valid_end", {31'd0, rd_valid}, 32'd0);
        chk("data_end", {24'd0, rd_data}, {24'd0, exp});
        za = 16'h0000;
        @(negedge fclk);
    endtask

    initial begin
        rst = 1'b1; zpos = 1'b0; zneg = 1'b0; za = 16'h0000;
        iorq_n = 1'b1; rd_n = 1'b1; m1_n = 1'b1; shadow_en = 1'b0;
        randomize_pagers();
        m_last = 8'hFF;
        repeat (3) @(negedge fclk);
        chk("reset_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_data", {24'd0, rd_data}, 32'hFF);
        rst = 1'b0;
        @(negedge fclk);

        // Page readback: port shows 3C in window 3, read returns C3.
        wr_pg1[3] = 8'hC3; wr_pg1[2] = 8'hFF; wr_pg1[1] = 8'h0F; wr_pg1[0] = 8'h55;
        @(negedge fclk);
        chk("page1_port", page1, 32'h3C00F0AA);
        do_in(16'h07BE, 1'b1, 1'b1, 1'b0, 2, 1'b0);
        chk("page_c3", {24'd0, m_last}, 32'hC3);

        // Flag bytes and open bus.
        m_ramnrom = 8'h5A; m_wrdis = 8'h81;
        do_in(16'h08BE, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        do_in(16'h0ABE, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        do_in(16'h0BBE, 1'b1, 1'b1, 1'b0, 1, 1'b0);
        do_in(16'hFFBE, 1'b1, 1'b1, 1'b0, 1, 1'b0);

        // Gating: shadow off, interrupt acknowledge, wrong port.
        do_in(16'h01BE, 1'b0, 1'b1, 1'b0, 2, 1'b0);
        do_in(16'h01BE, 1'b1, 1'b0, 1'b0, 2, 1'b0);
        do_in(16'h01BF, 1'b1, 1'b1, 1'b0, 2, 1'b0);

        // Snapshot stability, then the next read sees the new pager state.
        do_in(16'h02BE, 1'b1, 1'b1, 1'b0, 4, 1'b1);
        do_in(16'h02BE, 1'b1, 1'b1, 1'b0, 1, 1'b0);

        // Abort on the edge after the hit.
        do_in(16'h09BE, 1'b1, 1'b1, 1'b1, 0, 1'b0);

        // Reset during HOLD.
        @(negedge fclk);
        za = 16'h05BE; iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b1; shadow_en = 1'b1; zneg = 1'b1;
        @(negedge fclk);
        zneg = 1'b0;
        repeat (2) @(negedge fclk);
        chk("pre_rst_valid", {31'd0, rd_valid}, 32'd1);
        chk("pre_rst_data", {24'd0, rd_data}, {24'd0, ref_byte(8'h05)});
        rst = 1'b1;
        @(negedge fclk);
        chk("rst_hold_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_hold_data", {24'd0, rd_data}, 32'hFF);
        rst = 1'b0; iorq_n = 1'b1; rd_n = 1'b1;
        m_last = 8'hFF;
        @(negedge fclk);
        do_in(16'h06BE, 1'b1, 1'b1, 1'b0, 1, 1'b0);

        // Randomized transactions.
        for (int t = 0; t < 80; t++) begin
            logic [15:0] a;
            a[15:8] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            a[7:0]  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hBE;
            if ($urandom_range(0, 3) == 0) randomize_pagers();
            do_in(a, ($urandom_range(0, 5) != 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 7) == 0), int'($urandom_range(0, 4)),
                  ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
